// File: rtl/mapper_hotspot_if.sv
// Cartridge mapper bus shared by every mapper in the cartridge mux.
//   a_change    : cart address differs from the previous clk
//   sc          : Superchip RAM enable
//   a_in, d_in  : cart address / data bus
//   d_out       : direct data output (unused by ROM/RAM-path mappers)
//   flags_out   : mapper flags (unused by ROM/RAM-path mappers)
//   oe          : output-enable mask
//   ram_sel     : access targets cart RAM
//   ram_rw      : 1 = RAM read, 0 = RAM write
//   ram_a       : cart RAM address
//   rom_a       : absolute ROM address
//   bank        : current bank, zero-extended
//   bank_strobe : one-clk pulse on the edge a new bank is latched
// master drives the cart side, slave is the mapper.
interface mapper_hotspot_if;
  logic        a_change;
  logic        sc;
  logic [12:0] a_in;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic [15:0] flags_out;
  logic [7:0]  oe;
  logic        ram_sel;
  logic        ram_rw;
  logic [17:0] ram_a;
  logic [18:0] rom_a;
  logic [3:0]  bank;
  logic        bank_strobe;

  modport master (
    output a_change, sc, a_in, d_in,
    input  d_out, flags_out, oe, ram_sel, ram_rw, ram_a, rom_a, bank, bank_strobe
  );

  modport slave (
    input  a_change, sc, a_in, d_in,
    output d_out, flags_out, oe, ram_sel, ram_rw, ram_a, rom_a, bank, bank_strobe
  );
endinterface

// File: rtl/mapper_hotspot.sv
// Parametrised hotspot bank-switching mapper (F8/F6/F4/EF family) with
// optional Superchip RAM. A hotspot only switches the bank after the address
// has been stable for SETTLE clocks, and at most once per address phase.
// Ports:
//   clk   : master clock
//   reset : synchronous, active-high reset
//   bus   : mapper side of the cartridge mapper bus (see mapper_hotspot_if)
module mapper_hotspot #(
  parameter int unsigned BANKS      = 8,
  parameter logic [12:0] HOT_BASE   = 13'h1FF4,
  parameter int unsigned START_BANK = BANKS - 1,
  parameter int unsigned RAM_BYTES  = 128,
  parameter int unsigned SETTLE     = 2
) (
  input  logic            clk,
  input  logic            reset,
  mapper_hotspot_if.slave bus
);

  localparam int unsigned BW = $clog2(BANKS);
  localparam int unsigned RW = $clog2(RAM_BYTES);
  localparam logic [13:0] HotEnd = 14'(HOT_BASE) + 14'(BANKS);

  logic [BW-1:0] bank_q, bank_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          acted_q, acted_d;
  // Cleared by reset, set by the first a_change: a hotspot already held when
  // reset deasserts must wait for a fresh address phase before it can fire.
  logic          armed_q, armed_d;

  logic hot_hit;
  logic fire;
  logic ram_win;

  // Hotspot decode and fire qualification.
  always_comb begin
    hot_hit = bus.a_in[12] && ({1'b0, bus.a_in} >= {1'b0, HOT_BASE})
              && ({1'b0, bus.a_in} < HotEnd);
    fire    = !reset && !bus.a_change && armed_q && !acted_q
              && (cnt_q == 4'(SETTLE - 1)) && hot_hit;
  end

  // Settle counter, one-shot flag and bank register next state.
  always_comb begin
    cnt_d   = cnt_q;
    acted_d = acted_q;
    armed_d = armed_q;
    bank_d  = bank_q;
    if (bus.a_change) begin
      cnt_d   = 4'd0;
      acted_d = 1'b0;
      armed_d = 1'b1;
    end else begin
      if (cnt_q < 4'(SETTLE)) begin
        cnt_d = cnt_q + 4'd1;
      end
      if (fire) begin
        bank_d  = BW'(bus.a_in - HOT_BASE);
        acted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q  <= BW'(START_BANK);
      cnt_q   <= 4'd0;
      acted_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      bank_q  <= bank_d;
      cnt_q   <= cnt_d;
      acted_q <= acted_d;
      armed_q <= armed_d;
    end
  end

  // Address decode: ROM window, Superchip write/read windows at the bottom of
  // the cart space. The RAM window spans 2*RAM_BYTES; a_in[RW] picks read.
  always_comb begin
    ram_win     = bus.sc && ((bus.a_in[11:0] >> (RW + 1)) == 12'd0);
    bus.ram_sel = 1'b0;
    bus.ram_rw  = 1'b1;
    bus.oe      = 8'h00;
    if (bus.a_in[12]) begin
      if (ram_win) begin
        bus.ram_sel = 1'b1;
        bus.ram_rw  = bus.a_in[RW];
        bus.oe      = bus.a_in[RW] ? 8'hFF : 8'h00;
      end else begin
        bus.oe = 8'hFF;
      end
    end
  end

  assign bus.d_out       = 8'hFF;
  assign bus.flags_out   = 16'd0;
  assign bus.ram_a       = 18'(bus.a_in[RW-1:0]);
  assign bus.rom_a       = 19'({bank_q, bus.a_in[11:0]});
  assign bus.bank        = 4'(bank_q);
  assign bus.bank_strobe = fire;

endmodule

// File: tb/tb_mapper_hotspot.sv
module tb_mapper_hotspot;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_strobe;

  always #5 clk = ~clk;

  mapper_hotspot_if bus0 ();
  mapper_hotspot_if bus1 ();

  mapper_hotspot u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  mapper_hotspot #(
    .BANKS      (16),
    .HOT_BASE   (13'h1FE0),
    .START_BANK (3),
    .RAM_BYTES  (256),
    .SETTLE     (2)
  ) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clk on DUT0: inputs change just after the edge, sampled at the negedge.
  task automatic cyc0(input logic ac, input logic [12:0] a, input logic rst);
    @(posedge clk);
    #1;
    reset         = rst;
    bus0.a_change = ac;
    bus0.a_in     = a;
    @(negedge clk);
  endtask

  task automatic cyc1(input logic ac, input logic [12:0] a);
    @(posedge clk);
    #1;
    bus1.a_change = ac;
    bus1.a_in     = a;
    @(negedge clk);
  endtask

  initial begin
    reset         = 1'b1;
    bus0.a_change = 1'b0;
    bus0.sc       = 1'b0;
    bus0.a_in     = 13'h1123;
    bus0.d_in     = 8'h00;
    bus1.a_change = 1'b0;
    bus1.sc       = 1'b0;
    bus1.a_in     = 13'h0000;
    bus1.d_in     = 8'h00;

    // Reset defaults.
    cyc0(1'b0, 13'h1123, 1'b1);
    cyc0(1'b0, 13'h1123, 1'b1);
    check("rst_bank", 32'(bus0.bank), 32'd7);
    check("rst_rom_a", 32'(bus0.rom_a), 32'h07123);
    check("rst_oe", 32'(bus0.oe), 32'hFF);
    check("rst_ram_sel", 32'(bus0.ram_sel), 32'd0);
    check("rst_ram_rw", 32'(bus0.ram_rw), 32'd1);
    check("rst_flags", 32'(bus0.flags_out), 32'd0);
    check("rst_d_out", 32'(bus0.d_out), 32'hFF);
    check("rst_strobe", 32'(bus0.bank_strobe), 32'd0);
    check("rst_bank1", 32'(bus1.bank), 32'd3);
    cyc0(1'b1, 13'h1123, 1'b0);

    // Hotspot 1FF6: strobe on the 2nd stable clk, bank 2 afterwards.
    cyc0(1'b1, 13'h1FF6, 1'b0);
    check("f6_ac_strobe", 32'(bus0.bank_strobe), 32'd0);
    cyc0(1'b0, 13'h1FF6, 1'b0);
    check("f6_s1_strobe", 32'(bus0.bank_strobe), 32'd0);
    cyc0(1'b0, 13'h1FF6, 1'b0);
    check("f6_s2_strobe", 32'(bus0.bank_strobe), 32'd1);
    check("f6_s2_bank", 32'(bus0.bank), 32'd7);
    cyc0(1'b0, 13'h1FF6, 1'b0);
    check("f6_s3_strobe", 32'(bus0.bank_strobe), 32'd0);
    check("f6_s3_bank", 32'(bus0.bank), 32'd2);
    n_strobe = 0;
    for (int i = 0; i < 20; i++) begin
      cyc0(1'b0, 13'h1FF6, 1'b0);
      n_strobe += int'(bus0.bank_strobe);
    end
    check("f6_hold_strobes", 32'(n_strobe), 32'd0);
    cyc0(1'b1, 13'h1ABC, 1'b0);
    check("f6_rom_a", 32'(bus0.rom_a), 32'h02ABC);

    // 1FFC is one past the last hotspot: no fire.
    cyc0(1'b1, 13'h1FFC, 1'b0);
    cyc0(1'b0, 13'h1FFC, 1'b0);
    cyc0(1'b0, 13'h1FFC, 1'b0);
    check("above_strobe", 32'(bus0.bank_strobe), 32'd0);
    cyc0(1'b0, 13'h1FFC, 1'b0);
    check("above_bank", 32'(bus0.bank), 32'd2);

    // 1FFB is the last hotspot: bank 7.
    cyc0(1'b1, 13'h1FFB, 1'b0);
    cyc0(1'b0, 13'h1FFB, 1'b0);
    cyc0(1'b0, 13'h1FFB, 1'b0);
    check("top_strobe", 32'(bus0.bank_strobe), 32'd1);
    cyc0(1'b0, 13'h1FFB, 1'b0);
    check("top_bank", 32'(bus0.bank), 32'd7);

    // Glitch landing on the fire cycle restarts the settle window.
    n_strobe = 0;
    cyc0(1'b1, 13'h1FF5, 1'b0);
    n_strobe += int'(bus0.bank_strobe);
    cyc0(1'b0, 13'h1FF5, 1'b0);
    n_strobe += int'(bus0.bank_strobe);
    cyc0(1'b1, 13'h1FF5, 1'b0);
    check("glitch_strobe", 32'(bus0.bank_strobe), 32'd0);
    n_strobe += int'(bus0.bank_strobe);
    cyc0(1'b0, 13'h1FF5, 1'b0);
    check("glitch_s1_strobe", 32'(bus0.bank_strobe), 32'd0);
    n_strobe += int'(bus0.bank_strobe);
    cyc0(1'b0, 13'h1FF5, 1'b0);
    check("glitch_s2_strobe", 32'(bus0.bank_strobe), 32'd1);
    n_strobe += int'(bus0.bank_strobe);
    cyc0(1'b0, 13'h1FF5, 1'b0);
    n_strobe += int'(bus0.bank_strobe);
    check("glitch_count", 32'(n_strobe), 32'd1);
    check("glitch_bank", 32'(bus0.bank), 32'd1);

    // Returning to the current bank's hotspot still pulses the strobe.
    cyc0(1'b1, 13'h1FF5, 1'b0);
    cyc0(1'b0, 13'h1FF5, 1'b0);
    cyc0(1'b0, 13'h1FF5, 1'b0);
    check("rehit_strobe", 32'(bus0.bank_strobe), 32'd1);
    cyc0(1'b0, 13'h1FF5, 1'b0);
    check("rehit_bank", 32'(bus0.bank), 32'd1);

    // Superchip 128 B windows.
    bus0.sc = 1'b1;
    cyc0(1'b1, 13'h1005, 1'b0);
    check("sc_wr_sel", 32'(bus0.ram_sel), 32'd1);
    check("sc_wr_rw", 32'(bus0.ram_rw), 32'd0);
    check("sc_wr_oe", 32'(bus0.oe), 32'h00);
    check("sc_wr_ram_a", 32'(bus0.ram_a), 32'h5);
    cyc0(1'b1, 13'h1085, 1'b0);
    check("sc_rd_sel", 32'(bus0.ram_sel), 32'd1);
    check("sc_rd_rw", 32'(bus0.ram_rw), 32'd1);
    check("sc_rd_oe", 32'(bus0.oe), 32'hFF);
    check("sc_rd_ram_a", 32'(bus0.ram_a), 32'h5);
    cyc0(1'b1, 13'h107F, 1'b0);
    check("sc_wr_top_rw", 32'(bus0.ram_rw), 32'd0);
    cyc0(1'b1, 13'h1100, 1'b0);
    check("sc_past_sel", 32'(bus0.ram_sel), 32'd0);
    bus0.sc = 1'b0;
    cyc0(1'b1, 13'h1005, 1'b0);
    check("nosc_sel", 32'(bus0.ram_sel), 32'd0);
    check("nosc_oe", 32'(bus0.oe), 32'hFF);
    check("nosc_rw", 32'(bus0.ram_rw), 32'd1);
    cyc0(1'b1, 13'h0005, 1'b0);
    check("lo_oe", 32'(bus0.oe), 32'h00);
    check("lo_sel", 32'(bus0.ram_sel), 32'd0);

    // Reset on the clk before a pending fire at 1FF4.
    cyc0(1'b1, 13'h1FF4, 1'b0);
    cyc0(1'b0, 13'h1FF4, 1'b1);
    check("rstfire_strobe", 32'(bus0.bank_strobe), 32'd0);
    cyc0(1'b0, 13'h1FF4, 1'b0);
    check("rstfire_bank", 32'(bus0.bank), 32'd7);
    n_strobe = int'(bus0.bank_strobe);
    for (int i = 0; i < 5; i++) begin
      cyc0(1'b0, 13'h1FF4, 1'b0);
      n_strobe += int'(bus0.bank_strobe);
    end
    check("rstfire_hold", 32'(n_strobe), 32'd0);
    cyc0(1'b1, 13'h1FF4, 1'b0);
    cyc0(1'b0, 13'h1FF4, 1'b0);
    check("rearm_s1_strobe", 32'(bus0.bank_strobe), 32'd0);
    cyc0(1'b0, 13'h1FF4, 1'b0);
    check("rearm_s2_strobe", 32'(bus0.bank_strobe), 32'd1);
    cyc0(1'b0, 13'h1FF4, 1'b0);
    check("rearm_bank", 32'(bus0.bank), 32'd0);

    // 16 banks, HOT_BASE 1FE0, 256 B RAM.
    cyc1(1'b1, 13'h1FDF);
    cyc1(1'b0, 13'h1FDF);
    cyc1(1'b0, 13'h1FDF);
    check("b16_below_strobe", 32'(bus1.bank_strobe), 32'd0);
    cyc1(1'b1, 13'h1FEF);
    cyc1(1'b0, 13'h1FEF);
    cyc1(1'b0, 13'h1FEF);
    check("b16_strobe", 32'(bus1.bank_strobe), 32'd1);
    cyc1(1'b1, 13'h1ABC);
    check("b16_bank", 32'(bus1.bank), 32'd15);
    check("b16_rom_a", 32'(bus1.rom_a), 32'h0FABC);
    bus1.sc = 1'b1;
    cyc1(1'b1, 13'h1100);
    check("b16_rd_sel", 32'(bus1.ram_sel), 32'd1);
    check("b16_rd_rw", 32'(bus1.ram_rw), 32'd1);
    check("b16_rd_oe", 32'(bus1.oe), 32'hFF);
    check("b16_rd_ram_a", 32'(bus1.ram_a), 32'h0);
    cyc1(1'b1, 13'h10FF);
    check("b16_wr_rw", 32'(bus1.ram_rw), 32'd0);
    check("b16_wr_ram_a", 32'(bus1.ram_a), 32'hFF);
    cyc1(1'b1, 13'h1200);
    check("b16_past_sel", 32'(bus1.ram_sel), 32'd0);
    check("b16_past_oe", 32'(bus1.oe), 32'hFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mapper_hotspot.md
# mapper_hotspot

Parametrised hotspot bank-switching mapper for the 2600 cartridge path. It generalises the fixed F8/F6/F4/EF family into one block, with a configurable bank count, hotspot base and Superchip RAM size. Unlike the fixed mappers, a hotspot only takes effect after the address has been stable for a programmable number of clocks, and only once per address phase. It plugs into the cartridge mapper mux with the standard mapper port set, plus two status outputs.

## Interface
Parameters:
- BANKS, 8, number of 4 KB ROM banks; one of 2, 4, 8, 16. Bank register width BW = clog2(BANKS).
- HOT_BASE, 13'h1FF4, address of the hotspot for bank 0. Bank n hotspot = HOT_BASE+n. HOT_BASE+BANKS-1 must be ≤ 13'h1FFB.
- START_BANK, BANKS-1, bank selected after reset.
- RAM_BYTES, 128, Superchip RAM size; 128 or 256. RW = clog2(RAM_BYTES).
- SETTLE, 2, clean (a_change=0) clocks required before a hotspot fires; range 1..15.

Ports:
- clk  in  1  master clock.
- reset  in  1  synchronous, active-high reset.
- a_change  in  1  high on any clk where the cart address differs from the previous clk.
- sc  in  1  Superchip RAM enable.
- a_in  in  13  cart address bus.
- d_in  in  8  cart data bus (unused; ports kept for mux uniformity).
- d_out  out  8  constant 8'hFF (direct data not used).
- flags_out  out  16  constant 16'd0 (ROM or RAM path only).
- oe  out  8  output-enable mask.
- ram_sel  out  1  access targets cart RAM.
- ram_rw  out  1  1 = RAM read, 0 = RAM write.
- ram_a  out  18  cart RAM address.
- rom_a  out  19  absolute ROM address.
- bank  out  4  current bank, zero-extended.
- bank_strobe  out  1  one-clk pulse on the edge a new bank is latched.

## Operation
Registers: bank_r[BW-1:0], cnt[3:0] (settle counter), acted (hotspot already serviced this phase).
- a_change=1: cnt←0, acted←0; no switch on that edge regardless of address.
- a_change=0 and cnt<SETTLE: cnt←cnt+1. cnt saturates at SETTLE.
- Fire condition: a_change=0, cnt==SETTLE-1, acted=0, a_in[12]=1, HOT_BASE ≤ a_in < HOT_BASE+BANKS.
- On fire: bank_r←a_in-HOT_BASE (low BW bits), acted←1, bank_strobe=1 for that clk.
- Hotspots respond to reads and writes alike.
- A repeated hit on the current bank still pulses bank_strobe.
- Effective state machine per address phase: SETTLING (cnt<SETTLE-1) → FIRE (one clk) → DONE (acted=1, until next a_change).

Decode (combinational from a_in, sc, bank_r):
- a_in[12]=0: oe=8'h00, ram_sel=0, ram_rw=1.
- sc=1, a_in[11:RW+1]=0, a_in[RW]=0 (write window; $1000-$107F for 128 B, $1000-$10FF for 256 B): ram_sel=1, ram_rw=0, oe=8'h00. Reads here are also treated as writes.
- sc=1, a_in[11:RW+1]=0, a_in[RW]=1 (read window; $1080-$10FF for 128 B, $1100-$11FF for 256 B): ram_sel=1, ram_rw=1, oe=8'hFF.
- Otherwise, with a_in[12]=1: ram_sel=0, ram_rw=1, oe=8'hFF.
- ram_a = zero-extended a_in[RW-1:0].
- rom_a = zero-extended {bank_r, a_in[11:0]}. It is still driven during RAM windows, but is ignored by the mux there.

Reset values: bank_r=START_BANK, cnt=0, acted=0, bank_strobe=0. Combinational outputs follow from these values immediately.

## Timing
- Latency: a hotspot presented with a_change=1 on clk k, then held stable, fires on the edge ending clk k+SETTLE. The new bank appears on rom_a from clk k+SETTLE+1.
- Address glitch (a_change=1) before the fire edge: counter restarts and no switch occurs. A glitch that lands on the fire cycle also suppresses the fire.
- Holding a hotspot indefinitely produces exactly one fire.
- Leaving and returning to the same hotspot (two a_change events) fires again.
- Reset mid-settle: cnt and acted clear and bank_r=START_BANK on the next clk. A hotspot still held after reset deasserts does not fire until the next a_change.
- RAM write qualification against a_change is done downstream; this block drives ram_rw/ram_sel combinationally with zero latency.

## Test plan
- Reset, defaults (BANKS=8, HOT_BASE=1FF4, SETTLE=2): a_in=13'h1123 -> bank=7, rom_a=19'h07123, oe=FF, ram_sel=0, flags_out=0.
- a_in=13'h1FF6 with a_change=1 for 1 clk, then stable -> bank_strobe high on exactly 2nd stable clk, bank=2 next clk, rom_a for 13'h1ABC = 19'h02ABC; holding 20 more clks gives no further strobe.
- Glitch: 1FF5 for 1 stable clk, a_change pulse, 1FF5 again -> only one strobe, after the second 2-clk stable window; bank=1.
- sc=1, RAM_BYTES=128: a_in=13'h1005 -> ram_sel=1, ram_rw=0, oe=00, ram_a=5; a_in=13'h1085 -> ram_rw=1, oe=FF, ram_a=5. Same with sc=0 -> ram_sel=0, oe=FF.
- BANKS=16, HOT_BASE=1FE0, RAM_BYTES=256: hotspot 1FEF -> bank=15; a_in=13'h1100 with sc=1 -> read window, ram_a=0.
- Reset asserted on the clk before a pending fire at 1FF4 -> no strobe, bank=7; release with 1FF4 held -> no fire until a_change then 2 stable clks.
